// File: rtl/ripple_seq_ctrl.sv
// Multi-cycle wide adder sequencer: walks WIDTH-bit operands one nibble per
// cycle through an external 4-bit ripple_adder, carrying between slices in a register.
module ripple_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] op_a_r, op_a_s;
    logic [WIDTH-1:0] op_b_r, op_b_s;
    logic             carry_r, carry_s;
    logic [IDXW-1:0]  idx_r, idx_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             cout_r, cout_s;
    logic [3:0]       add_a_s, add_b_s;
    logic             add_cin_s;

    // Slice drive: select the current nibble pair of the captured operands.
    always_comb begin
        add_a_s   = 4'h0;
        add_b_s   = 4'h0;
        add_cin_s = 1'b0;
        if (state_r == ST_RUN) begin
            add_cin_s = carry_r;
            for (int i = 0; i < NSLICE; i++) begin
                if (idx_r == IDXW'(i)) begin
                    add_a_s = op_a_r[4*i +: 4];
                    add_b_s = op_b_r[4*i +: 4];
                end else begin
                    add_a_s = add_a_s;
                    add_b_s = add_b_s;
                end
            end
        end else begin
            add_cin_s = 1'b0;
        end
    end

    // Next-state and datapath update; kept apart from the slice drive so the
    // external adder path does not form a loop through one process.
    always_comb begin
        state_s = state_r;
        op_a_s  = op_a_r;
        op_b_s  = op_b_r;
        carry_s = carry_r;
        idx_s   = idx_r;
        sum_s   = sum_r;
        cout_s  = cout_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_a_s  = a;
                    op_b_s  = b;
                    carry_s = cin;
                    idx_s   = {IDXW{1'b0}};
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_r == IDXW'(i)) begin
                        sum_s[4*i +: 4] = add_sum;
                    end else begin
                        sum_s[4*i +: 4] = sum_r[4*i +: 4];
                    end
                end
                carry_s = add_cout;
                if (idx_r == LAST_IDX) begin
                    cout_s  = add_cout;
                    state_s = ST_DONE;
                end else begin
                    idx_s = idx_r + IDXW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_a_r  <= {WIDTH{1'b0}};
            op_b_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            op_a_r  <= op_a_s;
            op_b_r  <= op_b_s;
            carry_r <= carry_s;
            idx_r   <= idx_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
        end
    end

    assign busy    = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign done    = (state_r == ST_DONE);
    assign sum     = sum_r;
    assign cout    = cout_r;
    assign add_a   = add_a_s;
    assign add_b   = add_b_s;
    assign add_cin = add_cin_s;

endmodule

// File: tb/tb_ripple_seq_ctrl.sv
// Self-checking bench for ripple_seq_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_ripple_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ripple_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
        end
    endtask

    task automatic push_exp(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        exp_t        e;
        logic [16:0] full;
        full   = {1'b0, ta} + {1'b0, tb_v} + {16'h0000, tc};
        e.sum  = full[15:0];
        e.cout = full[16];
        sb.push_back(e);
    endtask

    // One full operation, called at a negedge while the DUT is idle.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        logic [15:0]  held;
        int unsigned  m, t;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        push_exp(ta, tb_v, tc);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            m = (32'd1 << (4 * k)) - 32'd1;
            t = (32'(ta) & m) + (32'(tb_v) & m) + 32'(tc);
            chk($sformatf("%s_add_a%0d", tag, k), 32'(add_a), (32'(ta) >> (4 * k)) & 32'hF);
            chk($sformatf("%s_add_b%0d", tag, k), 32'(add_b), (32'(tb_v) >> (4 * k)) & 32'hF);
            chk($sformatf("%s_add_cin%0d", tag, k), 32'(add_cin), t >> (4 * k));
            chk($sformatf("%s_nodone%0d", tag, k), 32'(done), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_add_a_idle"}, 32'(add_a), 32'd0);
        held = sum;
        pop_and_check(tag);
        @(negedge clk);
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(held));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 16'h0003, 16'h000C, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        run_op("cin_wrap", 16'h0001, 16'hFFFF, 1'b1);
        run_op("cin_mid", 16'h0003, 16'h000C, 1'b1);

        // start held high throughout; operands change during RUN
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        push_exp(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        a = 16'hFFFF; b = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold_nodone%0d", k), 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("hold_done1", 32'(done), 32'd1);
        pop_and_check("hold_first");
        push_exp(16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        chk("hold_idle_busy", 32'(busy), 32'd0);
        chk("hold_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_second_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("hold_done2", 32'(done), 32'd1);
        pop_and_check("hold_second");
        @(negedge clk);

        // asynchronous reset in the third RUN cycle
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_add_a", 32'(add_a), 32'hA);
        chk("abort_add_b", 32'(add_b), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_add_a0", 32'(add_a), 32'd0);
        chk("abort_add_b0", 32'(add_b), 32'd0);
        chk("abort_add_cin0", 32'(add_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone%0d", k), 32'(done), 32'd0);
        end
        run_op("after_abort", 16'hAAAA, 16'h5555, 1'b1);

        run_op("slices", 16'h4321, 16'h1234, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ripple_seq_ctrl.md
Name: ripple_seq_ctrl

Overview:
Multi-cycle sequencer that adds two WIDTH-bit operands on one external 4-bit ripple_adder slice. Each cycle it feeds the slice one nibble pair plus the registered carry, then stores the nibble sum and carry-out. This gives wide additions without replicating the adder. It sits between a requesting datapath (start/done handshake) and one ripple_adder instance.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, number of nibble slices; derived localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  operand A; captured when start is accepted
b  in  WIDTH  operand B; captured when start is accepted
cin  in  1  carry-in to slice 0; captured when start is accepted
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result valid
sum  out  WIDTH  result register
cout  out  1  carry out of slice NSLICE-1
add_a  out  4  to ripple_adder a
add_b  out  4  to ripple_adder b
add_cin  out  1  to ripple_adder cin
add_sum  in  4  from ripple_adder sum
add_cout  in  1  from ripple_adder cout

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; op_a, op_b, carry, idx, sum, cout all cleared to 0.
  - busy=0, done=0, add_a/add_b/add_cin=0.
- States: IDLE, RUN, DONE. Registered one-hot or binary encoding; all outputs driven from registers or from decode of state/idx.
- IDLE:
  - busy=0, done=0; add_* driven 0.
  - On start=1 at a clock edge: op_a<=a, op_b<=b, carry<=cin, idx<=0, go to RUN.
  - sum and cout are not cleared; they keep the previous result.
- RUN:
  - busy=1.
  - add_a=op_a[4*idx+3:4*idx], add_b=op_b[4*idx+3:4*idx], add_cin=carry. These are combinational from registers; the adder path is combinational and must settle within one cycle.
  - Each edge: sum[4*idx+3:4*idx]<=add_sum and carry<=add_cout.
  - If idx==NSLICE-1: cout<=add_cout and go to DONE. Otherwise idx<=idx+1.
  - Exactly NSLICE edges are spent in RUN.
- DONE:
  - busy=1, done=1 for exactly one cycle; add_* driven 0.
  - Next edge goes to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E(NSLICE). For WIDTH=16, done is high after E4.
- Throughput: one operation per NSLICE+2 cycles. Back-to-back issue is not supported: start is ignored in RUN and DONE.
- Result validity:
  - sum/cout are valid while done=1 and stay stable until the next start is accepted.
  - During RUN, sum holds a mix of new and old nibbles and is undefined for consumers.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; cout is the true carry of a+b+cin.
  - The carry propagates across slices only through the carry register, never combinationally between cycles.
- Operand stability: a, b and cin may change freely after the accept edge; only the captured copies are used.
- Reset during RUN or DONE aborts the operation with no done pulse. The next start after reset release behaves normally.

Test Plan:
(all with WIDTH=16)
- a=0x0003, b=0x000C, cin=0, start for one cycle -> busy rises next cycle; done high after 4 RUN cycles; sum=0x000F, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 slices; sum=0x0000, cout=1. Also check add_cin=1 in RUN cycles 2–4.
- a=0x0001, b=0xFFFF, cin=1 -> sum=0x0001, cout=1. Then a=0x0003, b=0x000C, cin=1 -> sum=0x0010, cout=0.
- start held high continuously with a=0x1234, b=0x1111 for the first request, then operands changed to 0xFFFF/0xFFFF during RUN:
  - first result is sum=0x2345, cout=0;
  - start is ignored in RUN and DONE;
  - a new operation is accepted in the first IDLE cycle and returns sum=0xFFFE, cout=1.
- rst_n pulsed low mid-RUN (idx=2) of 0xAAAA+0x5555 -> busy, done, sum, cout and add_* go to 0 immediately without a clock edge; no done pulse. Then 0xAAAA+0x5555, cin=1 -> sum=0x0000, cout=1.
- Per-cycle slice drive check for 0x4321+0x1234: add_a sequence 1,2,3,4 and add_b sequence 4,3,2,1 across RUN cycles; final sum=0x5555, cout=0.
